// File: rtl/cpri_rx_pkg.sv
// Shared definitions for the CPRI receive unpacker: header layout, payload
// layout, decompression limits and the parser state encoding.
package cpri_rx_pkg;

    localparam int HDR_MSB   = 63;
    localparam int HDR_LSB   = 29;
    localparam int MAGIC_MSB = 7;
    localparam int MAGIC_LSB = 0;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    localparam int SHIFT_MSB = 63;
    localparam int SHIFT_LSB = 60;
    localparam logic [3:0] MAX_SHIFT = 4'd9;

    localparam int RE_W          = 14;
    localparam int IQ_W          = 32;
    localparam int RES_PER_WORD  = 4;
    localparam int WORDS_PER_PRB = 3;

    // Packed in the same order as header bits [63:29], so a cast of that slice parses it.
    typedef struct packed {
        logic [3:0] ch_type;
        logic       cell_idx;
        logic [1:0] ant_idx;
        logic [6:0] slot_idx;
        logic [3:0] sym_idx;
        logic [8:0] prb_idx;
        logic [7:0] info;
    } hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    function automatic hdr_t parse_hdr(input logic [63:0] w);
        return hdr_t'(w[HDR_MSB:HDR_LSB]);
    endfunction

    function automatic logic magic_ok(input logic [63:0] w);
        return w[MAGIC_MSB:MAGIC_LSB] == HDR_MAGIC;
    endfunction

    function automatic logic [3:0] clamp_shift(input logic [3:0] s);
        return (s > MAX_SHIFT) ? MAX_SHIFT : s;
    endfunction

endpackage

// File: rtl/re_decompress.sv
// Expands one 14-bit block-floating-point RE (I7/Q7) to 16+16-bit IQ.
// Purely combinational; the caller supplies an already clamped shift.
module re_decompress
    import cpri_rx_pkg::*;
(
    input  logic [RE_W-1:0] re,
    input  logic [3:0]      shift,
    output logic [IQ_W-1:0] iq
);

    localparam int HALF = RE_W / 2;

    logic signed [15:0] i_ext;
    logic signed [15:0] q_ext;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;

    always_comb begin
        i_ext = {{(16-HALF){re[RE_W-1]}}, re[RE_W-1:HALF]};
        q_ext = {{(16-HALF){re[HALF-1]}}, re[HALF-1:0]};
        // Shift is at most 9, so a 7-bit signed value never overflows 16 bits.
        i_out = i_ext <<< shift;
        q_out = q_ext <<< shift;
        iq    = {i_out, q_out};
    end

endmodule

// File: rtl/cpri_rx_unpack.sv
// CPRI receive unpacker: header parse plus BFP payload expansion, latency 2.
// Optional header magic check is enabled by defining CPRI_RX_HDR_CHK_EN.
module cpri_rx_unpack
    import cpri_rx_pkg::*;
#(
    parameter int NUM_PRB = 4,
    parameter int CNT_W   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_iq_rx_valid,
    input  logic                                i_iq_rx_sop,
    input  logic [63:0]                         i_iq_rx_data,
    output logic                                o_re_vld,
    output logic                                o_re_sop,
    output logic                                o_re_eop,
    output logic [RES_PER_WORD*IQ_W-1:0]        o_re_data,
    output logic [3:0]                          o_ch_type,
    output logic                                o_cell_idx,
    output logic [1:0]                          o_ant_idx,
    output logic [6:0]                          o_slot_idx,
    output logic [3:0]                          o_sym_idx,
    output logic [8:0]                          o_prb_idx,
    output logic [7:0]                          o_info,
    output logic                                o_abort,
    output logic                                o_err_shift,
    output logic                                o_err_hdr,
    output logic [CNT_W-1:0]                    o_drop_cnt
);

    localparam int PAY_WORDS = WORDS_PER_PRB * NUM_PRB;
    localparam int WC_W      = (PAY_WORDS > 1) ? $clog2(PAY_WORDS) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(PAY_WORDS - 1);

    logic        s1_vld;
    logic        s1_sop;
    logic [63:0] s1_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sop  <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_vld  <= i_iq_rx_valid;
            s1_sop  <= i_iq_rx_sop;
            s1_data <= i_iq_rx_data;
        end
    end

    state_t          state, state_nxt;
    logic [WC_W-1:0] word_cnt, word_cnt_nxt;
    logic [1:0]      phase, phase_nxt;
    logic [8:0]      prb, prb_nxt;
    hdr_t            hdr, hdr_nxt;
    hdr_t            hdr_in;
    logic            hdr_ok;
    logic            emit, emit_sop, emit_eop, abort, drop_inc;

    assign hdr_in = parse_hdr(s1_data);

`ifdef CPRI_RX_HDR_CHK_EN
    assign hdr_ok = magic_ok(s1_data);
`else
    assign hdr_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            phase      <= '0;
            prb        <= '0;
            hdr        <= '0;
            o_drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            phase    <= phase_nxt;
            prb      <= prb_nxt;
            hdr      <= hdr_nxt;
            if (drop_inc && (o_drop_cnt != {CNT_W{1'b1}}))
                o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        phase_nxt    = phase;
        prb_nxt      = prb;
        hdr_nxt      = hdr;
        emit         = 1'b0;
        emit_sop     = 1'b0;
        emit_eop     = 1'b0;
        abort        = 1'b0;
        drop_inc     = 1'b0;

        if (s1_vld && s1_sop) begin
            // A sop is always a header, whatever state it interrupts.
            abort = (state == ST_PAYLOAD);
            if (hdr_ok) begin
                hdr_nxt      = hdr_in;
                prb_nxt      = hdr_in.prb_idx;
                word_cnt_nxt = '0;
                phase_nxt    = '0;
                state_nxt    = ST_PAYLOAD;
            end else begin
                drop_inc  = 1'b1;
                state_nxt = ST_DROP;
            end
        end else if (s1_vld) begin
            case (state)
                ST_PAYLOAD: begin
                    emit     = 1'b1;
                    emit_sop = (word_cnt == '0);
                    emit_eop = (word_cnt == LAST_WORD);
                    if (emit_eop) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                    if (phase == 2'd2) begin
                        phase_nxt = 2'd0;
                        prb_nxt   = prb + 9'd1;
                    end else begin
                        phase_nxt = phase + 2'd1;
                    end
                end
                default: drop_inc = 1'b1;
            endcase
        end
    end

    logic [3:0]                   raw_shift;
    logic [3:0]                   eff_shift;
    logic [RES_PER_WORD*IQ_W-1:0] dec_data;

    assign raw_shift = s1_data[SHIFT_MSB:SHIFT_LSB];
    assign eff_shift = clamp_shift(raw_shift);

    for (genvar k = 0; k < RES_PER_WORD; k++) begin : g_re
        re_decompress u_re (
            .re    (s1_data[k*RE_W +: RE_W]),
            .shift (eff_shift),
            .iq    (dec_data[k*IQ_W +: IQ_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_re_vld    <= 1'b0;
            o_re_sop    <= 1'b0;
            o_re_eop    <= 1'b0;
            o_re_data   <= '0;
            o_ch_type   <= '0;
            o_cell_idx  <= 1'b0;
            o_ant_idx   <= '0;
            o_slot_idx  <= '0;
            o_sym_idx   <= '0;
            o_prb_idx   <= '0;
            o_info      <= '0;
            o_abort     <= 1'b0;
            o_err_shift <= 1'b0;
        end else begin
            o_re_vld    <= emit;
            o_re_sop    <= emit_sop;
            o_re_eop    <= emit_eop;
            o_abort     <= abort;
            o_err_shift <= emit && (raw_shift > MAX_SHIFT);
            if (emit) begin
                o_re_data  <= dec_data;
                o_prb_idx  <= prb;
                o_ch_type  <= hdr.ch_type;
                o_cell_idx <= hdr.cell_idx;
                o_ant_idx  <= hdr.ant_idx;
                o_slot_idx <= hdr.slot_idx;
                o_sym_idx  <= hdr.sym_idx;
                o_info     <= hdr.info;
            end
        end
    end

`ifdef CPRI_RX_HDR_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) o_err_hdr <= 1'b0;
        else     o_err_hdr <= s1_vld && s1_sop && !hdr_ok;
    end
`else
    assign o_err_hdr = 1'b0;
`endif

endmodule
